// File: rtl/rapcore_pkg.sv
// Shared types and defaults for the step/direction receiver: FSM states,
// effective-direction encoding and default parameter values.
package rapcore_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } step_state_e;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } eff_dir_e;

  localparam int unsigned DEF_POS_W      = 32;
  localparam int unsigned DEF_FILTER_LEN = 3;
  localparam int unsigned DEF_DIR_SETUP  = 4;
  localparam int unsigned DEF_PER_W      = 24;

  function automatic eff_dir_e eff_dir(input logic dir_filt, input logic invert);
    return eff_dir_e'(dir_filt ^ invert);
  endfunction

endpackage

// File: rtl/step_dir_receiver_input_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample agreement filter.
// Also flags synchronized high runs that end before reaching FILTER_LEN samples.
module input_filter
  import rapcore_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic filt_o,
  output logic changed_o,
  output logic short_high_o
);
  localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);

  logic                  sync1_q, sync2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic [RUN_W-1:0]      run_q, run_d;

  always_comb begin
    hist_d    = hist_q << 1;
    hist_d[0] = sync2_q;

    // The window only ever holds synchronized samples, never the raw pin.
    filt_d = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end

    run_d = '0;
    if (sync2_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      filt_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  assign filt_o       = filt_q;
  assign changed_o    = (filt_d != filt_q);
  assign short_high_o = !sync2_q && (run_q != '0) && (run_q < RUN_MAX);

endmodule

// File: rtl/step_dir_receiver.sv
// Step/direction receiver: filters the step and dir pins, emits one strobe per
// accepted step edge, and tracks position, step period and sticky error flags.
module step_dir_receiver
  import rapcore_pkg::*;
#(
  parameter int unsigned POS_W      = DEF_POS_W,
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned DIR_SETUP  = DEF_DIR_SETUP,
  parameter int unsigned PER_W      = DEF_PER_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    enable,
  input  logic                    invert_dir,
  input  logic                    clear_pos,
  input  logic                    clear_err,
  output logic                    step_strobe,
  output logic                    step_dir,
  output logic signed [POS_W-1:0] position,
  output logic [PER_W-1:0]        last_period,
  output logic                    dir_setup_err,
  output logic                    glitch_seen
);
  localparam int unsigned SET_W = $clog2(DIR_SETUP + 1);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(DIR_SETUP);
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic step_filt, step_chg_unused, step_short;
  logic dir_filt, dir_chg, dir_short_unused;

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filter (
    .clk          (clk),
    .reset        (reset),
    .pin_i        (step),
    .filt_o       (step_filt),
    .changed_o    (step_chg_unused),
    .short_high_o (step_short)
  );

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filter (
    .clk          (clk),
    .reset        (reset),
    .pin_i        (dir),
    .filt_o       (dir_filt),
    .changed_o    (dir_chg),
    .short_high_o (dir_short_unused)
  );

  step_state_e             state_q;
  logic                    strobe_q, pend_err_q;
  eff_dir_e                pend_dir_q;
  logic [SET_W-1:0]        stable_q, stable_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    step_dir_q, step_dir_d;
  logic [PER_W-1:0]        per_cnt_q, per_cnt_d, last_per_q, last_per_d;
  logic                    setup_err_q, setup_err_d, glitch_q, glitch_d;

  // Step direction and setup verdict are captured at the edge, applied a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      strobe_q   <= 1'b0;
      pend_dir_q <= DIR_REV;
      pend_err_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step_filt) begin
            state_q <= ST_HIGH;
            if (enable) begin
              strobe_q   <= 1'b1;
              pend_dir_q <= eff_dir(dir_filt, invert_dir);
              pend_err_q <= (stable_q < SET_MAX);
            end
          end
        end
        ST_HIGH: begin
          if (!step_filt) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stable_d = stable_q;
    if (dir_chg) begin
      stable_d = '0;
    end else if (stable_q != SET_MAX) begin
      stable_d = stable_q + 1'b1;
    end

    per_cnt_d  = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
    last_per_d = last_per_q;
    pos_d      = pos_q;
    step_dir_d = step_dir_q;
    if (strobe_q) begin
      per_cnt_d  = '0;
      last_per_d = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;
      pos_d      = (pend_dir_q == DIR_FWD) ? pos_q + POS_ONE : pos_q - POS_ONE;
      step_dir_d = (pend_dir_q == DIR_FWD);
    end
    // A clear drops any step landing in the same cycle.
    if (clear_pos) begin
      pos_d = '0;
    end

    setup_err_d = (strobe_q && pend_err_q) || (setup_err_q && !clear_err);
    glitch_d    = step_short || (glitch_q && !clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q    <= '0;
      per_cnt_q   <= PER_MAX;
      last_per_q  <= '0;
      pos_q       <= '0;
      step_dir_q  <= 1'b0;
      setup_err_q <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      stable_q    <= stable_d;
      per_cnt_q   <= per_cnt_d;
      last_per_q  <= last_per_d;
      pos_q       <= pos_d;
      step_dir_q  <= step_dir_d;
      setup_err_q <= setup_err_d;
      glitch_q    <= glitch_d;
    end
  end

  assign step_strobe   = strobe_q;
  assign step_dir      = step_dir_q;
  assign position      = pos_q;
  assign last_period   = last_per_q;
  assign dir_setup_err = setup_err_q;
  assign glitch_seen   = glitch_q;

endmodule

// File: tb/tb_step_dir_receiver.sv
// Bench for step_dir_receiver: directed vector table, hand-written corner
// sequences and randomized pin activity against a per-cycle reference model.
module tb_step_dir_receiver;
  localparam int FL   = 3;
  localparam int DS   = 4;
  localparam int PW   = 24;
  localparam int POSW = 8;
  localparam logic [PW-1:0] PMAX = '1;

  logic clk = 1'b0;
  logic reset = 1'b1, step = 1'b0, dir = 1'b0, enable = 1'b0;
  logic invert_dir = 1'b0, clear_pos = 1'b0, clear_err = 1'b0;
  logic step_strobe, step_dir, dir_setup_err, glitch_seen;
  logic signed [POSW-1:0] position;
  logic [PW-1:0] last_period;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_strobe = 0, last_strobe_cyc = 0, rise_cyc = 0;

  step_dir_receiver #(.POS_W(POSW), .FILTER_LEN(FL), .DIR_SETUP(DS), .PER_W(PW)) dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .enable(enable),
    .invert_dir(invert_dir), .clear_pos(clear_pos), .clear_err(clear_err),
    .step_strobe(step_strobe), .step_dir(step_dir), .position(position),
    .last_period(last_period), .dir_setup_err(dir_setup_err), .glitch_seen(glitch_seen)
  );

  always #5 clk = ~clk;

  // Reference model. ms/md hold pin samples, index k = sample taken k edges ago.
  // A filtered value follows a value once FL samples agree; those samples
  // reach the window 3 edges after the pin is sampled (2 sync + window register).
  logic ms [0:FL+3];
  logic md [0:FL+3];
  logic m_fs, m_fs_prev, m_fd, m_strobe, m_pdir, m_perr, m_sdir, m_serr, m_glitch;
  logic signed [POSW-1:0] m_pos;
  logic [PW-1:0] m_last;
  int m_since, m_stable;

  task automatic model_step();
    logic ws1, ws0, wd1, wd0, g, fs_n, fd_n, strobe_n;
    int run;
    if (reset) begin
      for (int k = 0; k <= FL + 3; k++) begin ms[k] = 1'b0; md[k] = 1'b0; end
      m_fs = 0; m_fs_prev = 0; m_fd = 0; m_strobe = 0; m_pdir = 0; m_perr = 0;
      m_sdir = 0; m_serr = 0; m_glitch = 0; m_pos = '0; m_last = '0;
      m_since = -1; m_stable = 0;
      return;
    end
    for (int k = FL + 3; k > 0; k--) begin ms[k] = ms[k-1]; md[k] = md[k-1]; end
    ms[0] = step;
    md[0] = dir;
    ws1 = 1; ws0 = 1; wd1 = 1; wd0 = 1;
    for (int k = 3; k <= FL + 2; k++) begin
      ws1 &= ms[k]; ws0 &= !ms[k]; wd1 &= md[k]; wd0 &= !md[k];
    end
    fs_n = ws1 ? 1'b1 : (ws0 ? 1'b0 : m_fs);
    fd_n = wd1 ? 1'b1 : (wd0 ? 1'b0 : m_fd);
    run = 0;
    for (int k = 3; k <= FL + 2; k++) begin
      if (!ms[k]) break;
      run++;
    end
    g = !ms[2] && run >= 1 && run < FL;
    strobe_n = enable && m_fs && !m_fs_prev;

    if (m_strobe) begin
      m_pos  = m_pdir ? m_pos + 8'sd1 : m_pos - 8'sd1;
      m_sdir = m_pdir;
      m_last = (m_since < 0 || m_since + 1 > int'(PMAX)) ? PMAX : PW'(m_since + 1);
      m_since = 0;
    end else if (m_since >= 0) begin
      m_since++;
    end
    if (clear_pos) m_pos = '0;
    m_serr   = (m_strobe && m_perr) || (m_serr && !clear_err);
    m_glitch = g || (m_glitch && !clear_err);
    if (strobe_n) begin
      m_pdir = m_fd ^ invert_dir;
      m_perr = (m_stable < DS);
    end
    m_stable  = (fd_n != m_fd) ? 0 : ((m_stable < DS) ? m_stable + 1 : DS);
    m_strobe  = strobe_n;
    m_fs_prev = m_fs;
    m_fs      = fs_n;
    m_fd      = fd_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    if (step_strobe === 1'b1) begin
      n_strobe++;
      last_strobe_cyc = cyc;
    end
    n_tests++;
    if ({step_strobe, step_dir, position, last_period, dir_setup_err, glitch_seen} !==
        {m_strobe, m_sdir, m_pos, m_last, m_serr, m_glitch}) begin
      n_fail++;
      $display("FAIL model cycle %0d: got strb=%b dir=%b pos=%0d per=%0d serr=%b gl=%b, expected strb=%b dir=%b pos=%0d per=%0d serr=%b gl=%b",
               cyc, step_strobe, step_dir, position, last_period, dir_setup_err, glitch_seen,
               m_strobe, m_sdir, m_pos, m_last, m_serr, m_glitch);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    step = 1'b1;
    for (int i = 0; i < hi; i++) begin
      tick();
      if (i == 0) rise_cyc = cyc;
    end
    step = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " strobe"}, step_strobe, 0);
    chk({tag, " step_dir"}, step_dir, 0);
    chk({tag, " position"}, position, 0);
    chk({tag, " last_period"}, last_period, 0);
    chk({tag, " dir_setup_err"}, dir_setup_err, 0);
    chk({tag, " glitch_seen"}, glitch_seen, 0);
  endtask

  typedef struct {
    logic clr;
    logic d;
    logic inv;
    int   n;
    int   hi;
    int   lo;
    int   exp_pos;
    logic exp_sdir;
    int   exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k, run_left;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5, 8, 8, -5, 1'b0, 16};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5, 8, 8,  0, 1'b1, 16};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 3, 4, 4, -3, 1'b0,  8};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3, 3, 5,  0, 1'b1,  8};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2, 6, 6, -2, 1'b0, 12};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_state("reset");

    // Ten forward steps after a long dir hold.
    enable = 1'b1;
    dir = 1'b1;
    repeat (20) tick();
    s0 = n_strobe;
    for (int p = 0; p < 10; p++) begin
      pulse(8, 8);
      if (p == 0) chk("first strobe latency", last_strobe_cyc - rise_cyc, FL + 3);
    end
    chk("10 pulses strobes", n_strobe - s0, 10);
    chk("10 pulses position", position, 10);
    chk("10 pulses last_period", last_period, 16);
    chk("10 pulses dir_setup_err", dir_setup_err, 0);
    chk("10 pulses glitch_seen", glitch_seen, 0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].clr) begin
        clear_pos = 1'b1;
        tick();
        clear_pos = 1'b0;
      end
      dir = vecs[v].d;
      invert_dir = vecs[v].inv;
      repeat (16) tick();
      s0 = n_strobe;
      repeat (vecs[v].n) pulse(vecs[v].hi, vecs[v].lo);
      chk($sformatf("vec%0d strobes", v), n_strobe - s0, vecs[v].n);
      chk($sformatf("vec%0d position", v), position, vecs[v].exp_pos);
      chk($sformatf("vec%0d step_dir", v), step_dir, vecs[v].exp_sdir);
      chk($sformatf("vec%0d last_period", v), last_period, vecs[v].exp_last);
      chk($sformatf("vec%0d dir_setup_err", v), dir_setup_err, 0);
      chk($sformatf("vec%0d glitch_seen", v), glitch_seen, 0);
    end

    // Disabled steps, and re-enabling while the filtered step is high.
    enable = 1'b0;
    s0 = n_strobe;
    pulse(8, 8);
    step = 1'b1;
    repeat (8) tick();
    enable = 1'b1;
    repeat (8) tick();
    step = 1'b0;
    repeat (8) tick();
    chk("enable strobes", n_strobe - s0, 0);
    chk("enable position", position, -2);

    // Short step pulse is rejected and flagged.
    s0 = n_strobe;
    pulse(2, 10);
    chk("glitch strobes", n_strobe - s0, 0);
    chk("glitch flag set", glitch_seen, 1);
    chk("glitch position", position, -2);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("glitch flag cleared", glitch_seen, 0);

    // Dir changes two cycles ahead of the step edge.
    dir = 1'b1;
    tick();
    tick();
    s0 = n_strobe;
    pulse(8, 8);
    chk("setup strobes", n_strobe - s0, 1);
    chk("setup err set", dir_setup_err, 1);
    chk("setup position", position, -1);
    chk("setup step_dir", step_dir, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("setup err cleared", dir_setup_err, 0);

    // Position wrap at the signed limit.
    clear_pos = 1'b1;
    tick();
    clear_pos = 1'b0;
    repeat (10) tick();
    repeat (127) pulse(4, 4);
    chk("wrap position 127", position, 127);
    pulse(4, 4);
    chk("wrap position -128", position, -128);

    // clear_pos in the same cycle as a strobe.
    step = 1'b1;
    k = 0;
    tick();
    while (step_strobe !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("clear coincident strobe seen", step_strobe, 1);
    clear_pos = 1'b1;
    tick();
    clear_pos = 1'b0;
    chk("clear coincident position", position, 0);
    step = 1'b0;
    repeat (8) tick();
    chk("clear coincident position after", position, 0);

    // Reset while the filtered step is high, pin held through release.
    step = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk_reset_state("mid-high reset");
    reset = 1'b0;
    s0 = n_strobe;
    repeat (20) tick();
    chk("post-reset strobes", n_strobe - s0, 1);
    chk("post-reset last_period", last_period, PMAX);
    chk("post-reset position", position, 1);
    step = 1'b0;
    repeat (8) tick();

    // Randomized pin activity against the model.
    run_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        step = ~step;
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      if ($urandom_range(0, 24) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) invert_dir = ~invert_dir;
      enable    = ($urandom_range(0, 9) != 0);
      clear_pos = ($urandom_range(0, 59) == 0);
      clear_err = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    clear_pos = 1'b0;
    clear_err = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_dir_receiver.md
STEP_DIR_RECEIVER -- requirements
Module: step_dir_receiver

Interface
REQ-001 Parameter POS_W, default 32: width of the signed position accumulator.
REQ-002 Parameter FILTER_LEN, default 3: consecutive agreeing samples required before a filtered input changes (1..15).
REQ-003 Parameter DIR_SETUP, default 4: cycles the filtered dir must be stable before an accepted step edge.
REQ-004 Parameter PER_W, default 24: width of the step-period counter.
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 step  in  1  asynchronous step pin; a rising edge requests one step.
REQ-008 dir  in  1  asynchronous direction pin; 1 = forward.
REQ-009 enable  in  1  accept steps when high.
REQ-010 invert_dir  in  1  inverts dir polarity.
REQ-011 clear_pos  in  1  synchronous position clear, level-sensitive.
REQ-012 clear_err  in  1  clears sticky error flags.
REQ-013 step_strobe  out  1  one-cycle pulse per accepted step.
REQ-014 step_dir  out  1  effective direction of the last accepted step.
REQ-015 position  out  POS_W  signed two's-complement step count.
REQ-016 last_period  out  PER_W  cycles between the last two accepted steps, saturating.
REQ-017 dir_setup_err  out  1  sticky: a step arrived with dir stable fewer than DIR_SETUP cycles.
REQ-018 glitch_seen  out  1  sticky: a step-high pulse shorter than FILTER_LEN samples was rejected.

Function
REQ-019 step and dir SHALL each pass through a 2-flop synchronizer and then a filter; the filtered value changes only after FILTER_LEN consecutive synchronized samples differ from it.
REQ-020 Latency SHALL be exactly FILTER_LEN+3 cycles from the first clk edge sampling step=1 to step_strobe=1; position, step_dir and last_period update on the strobe cycle's following edge.
REQ-021 The FSM SHALL have states IDLE (filtered step low) and HIGH (filtered step high); IDLE->HIGH on a filtered rise, HIGH->IDLE on a filtered fall.
REQ-022 step_strobe SHALL assert only on the IDLE->HIGH transition with enable=1.
REQ-023 With enable=0, the FSM SHALL still track filtered step, so re-enabling during HIGH produces no strobe.
REQ-024 Effective direction SHALL be filtered dir XOR invert_dir; a strobe adds +1 if 1, -1 if 0, wrapping modulo 2^POS_W with no saturation.
REQ-025 A dir stability counter SHALL clear on every filtered dir change and saturate at DIR_SETUP; a strobe with the counter below DIR_SETUP sets dir_setup_err and the step is still counted with the current direction.
REQ-026 A synchronized step high run that ends before reaching FILTER_LEN samples SHALL set glitch_seen and produce no step.
REQ-027 The period counter SHALL increment every cycle and saturate at 2^PER_W-1; on a strobe, last_period <= min(counter+1, 2^PER_W-1) and the counter <= 0.
REQ-028 clear_pos SHALL have priority: position <= 0, and a coincident strobe is not counted, though step_strobe still pulses.
REQ-029 clear_err SHALL clear both sticky flags; a coincident setting event wins, and the flag stays 1.

Reset
REQ-030 On reset: state IDLE; synchronizers and filters 0; position 0; step_strobe 0; step_dir 0; last_period 0; period counter 2^PER_W-1; dir stability counter 0; both flags 0.
REQ-031 Reset mid-HIGH SHALL discard the pulse; a step pin still high after reset filters to HIGH and emits one strobe if enable=1.

Structure
REQ-032 FSM state encoding, default parameter constants and the effective-direction encoding SHALL reside in the shared package rapcore_pkg.
REQ-033 The synchronizer+filter SHALL be one sub-module, input_filter, instantiated twice (step, dir).

Verification
REQ-034 FILTER_LEN=3, enable=1, dir=1 held 20 cycles, then 10 step pulses 8 cycles high/8 low -> 10 strobes, first 6 cycles after the first step-high edge; position=10; last_period=16; no flags.
REQ-035 dir=0, invert_dir=0, 5 pulses -> position=-5; then invert_dir=1, 5 pulses -> position=0; step_dir=1.
REQ-036 2-cycle step pulse -> no strobe, glitch_seen=1; clear_err -> glitch_seen=0.
REQ-037 dir toggled 2 cycles before the filtered step edge (DIR_SETUP=4) -> dir_setup_err=1; step counted with the new direction.
REQ-038 POS_W=8, position=127, one forward step -> position=-128; clear_pos coincident with a strobe -> position=0, strobe seen.
REQ-039 Reset asserted while filtered step is HIGH, step held high through release -> exactly one strobe after release; period counter saturated, so last_period=2^PER_W-1.
